// File: rtl/instr_fetch_unit_if.sv
// Bundle of the fetch unit's handshake/bus signals: start control, instruction
// memory port, decode-side valid/ready stream and the redirect path from execute.
interface instr_fetch_unit_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 32
);
  logic                   start;
  logic                   imem_req;
  logic [ADDR_WIDTH-1:0]  imem_addr;
  logic [INSTR_WIDTH-1:0] imem_rdata;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [5:0]             out_opcode;
  logic [ADDR_WIDTH-1:0]  out_pc;
  logic                   redirect;
  logic [ADDR_WIDTH-1:0]  redirect_target;

  // Fetch unit side
  modport master (
    input  start,
    output imem_req, imem_addr,
    input  imem_rdata,
    output out_valid,
    input  out_ready,
    output out_instr, out_opcode, out_pc,
    input  redirect, redirect_target
  );

  // Environment side (memory, decoder, execute)
  modport slave (
    output start,
    input  imem_req, imem_addr,
    output imem_rdata,
    input  out_valid,
    output out_ready,
    input  out_instr, out_opcode, out_pc,
    output redirect, redirect_target
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, credit-limited memory requests, response FIFO
// toward decode, and redirect handling that flushes and drops stale responses.
module instr_fetch_unit #(
  parameter int ADDR_WIDTH  = 16,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input logic                clk,
  input logic                rst,
  instr_fetch_unit_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0]           DEPTH_C = (CW + 1)'(DEPTH);
  localparam logic [CW-1:0]         CNT_ONE = {{(CW - 1){1'b0}}, 1'b1};
  localparam logic [PW-1:0]         PTR_ONE = {{(PW - 1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] PC_ONE  = {{(ADDR_WIDTH - 1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state_r;
  state_t                 state_next_s;
  logic [ADDR_WIDTH-1:0]  fetch_pc_r;
  logic [ADDR_WIDTH-1:0]  req_addr_r;
  logic                   req_r;
  logic                   req_next_s;
  logic                   inflight_r;
  logic                   drop_r;
  logic                   out_valid_r;
  logic [PW-1:0]          rd_ptr_r;
  logic [PW-1:0]          wr_ptr_r;
  logic [CW-1:0]          count_r;
  logic [CW-1:0]          count_next_s;
  logic [INSTR_WIDTH-1:0] fifo_instr_r [DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_pc_r    [DEPTH];
  logic                   run_s;
  logic                   redir_s;
  logic                   enq_s;
  logic                   deq_s;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state: IDLE waits for start, RUN is only left through reset
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_next_s = RUN;
        else           state_next_s = IDLE;
      end
      RUN:     state_next_s = RUN;
      default: state_next_s = IDLE;
    endcase
  end

  // FIFO occupancy and the next-cycle request decision (imem_req is a flop)
  always_comb begin
    run_s        = (state_r == RUN);
    redir_s      = run_s && bus.redirect;
    deq_s        = out_valid_r && bus.out_ready;
    enq_s        = inflight_r && !drop_r;
    count_next_s = count_r;
    if (redir_s)                count_next_s = {CW{1'b0}};
    else if (enq_s && !deq_s)   count_next_s = count_r + CNT_ONE;
    else if (deq_s && !enq_s)   count_next_s = count_r - CNT_ONE;
    else                        count_next_s = count_r;
    // Next cycle's inflight is this cycle's request; a dequeue only frees credit once it lands
    if (state_next_s == RUN) begin
      req_next_s = (({1'b0, count_next_s} + {{CW{1'b0}}, req_r}) < DEPTH_C);
    end else begin
      req_next_s = 1'b0;
    end
  end

  // Fetch PC, request tracking, drop flag and FIFO storage
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r  <= {ADDR_WIDTH{1'b0}};
      req_addr_r  <= {ADDR_WIDTH{1'b0}};
      req_r       <= 1'b0;
      inflight_r  <= 1'b0;
      drop_r      <= 1'b0;
      out_valid_r <= 1'b0;
      rd_ptr_r    <= {PW{1'b0}};
      wr_ptr_r    <= {PW{1'b0}};
      count_r     <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        fifo_instr_r[i] <= {INSTR_WIDTH{1'b0}};
        fifo_pc_r[i]    <= {ADDR_WIDTH{1'b0}};
      end
    end else begin
      req_r       <= req_next_s;
      inflight_r  <= req_r;
      drop_r      <= redir_s && req_r;
      count_r     <= count_next_s;
      out_valid_r <= (count_next_s != {CW{1'b0}});
      if (req_r) req_addr_r <= fetch_pc_r;
      else       req_addr_r <= req_addr_r;

      if (redir_s)                          fetch_pc_r <= bus.redirect_target;
      else if (req_r)                       fetch_pc_r <= fetch_pc_r + PC_ONE;
      else if (state_r == IDLE && bus.start) fetch_pc_r <= {ADDR_WIDTH{1'b0}};
      else                                  fetch_pc_r <= fetch_pc_r;

      // Redirect wins over a same-cycle enqueue: the flush discards it
      if (redir_s) begin
        rd_ptr_r <= {PW{1'b0}};
        wr_ptr_r <= {PW{1'b0}};
      end else begin
        if (enq_s) begin
          fifo_instr_r[wr_ptr_r] <= bus.imem_rdata;
          fifo_pc_r[wr_ptr_r]    <= req_addr_r;
          wr_ptr_r               <= wr_ptr_r + PTR_ONE;
        end
        if (deq_s) rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  assign bus.imem_req   = req_r;
  assign bus.imem_addr  = fetch_pc_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.out_instr  = fifo_instr_r[rd_ptr_r];
  assign bus.out_opcode = fifo_instr_r[rd_ptr_r][INSTR_WIDTH-1 -: 6];
  assign bus.out_pc     = fifo_pc_r[rd_ptr_r];

endmodule
